// File: rtl/snoop_pkg.sv
// Shared field layout, opcodes and FSM state encoding for the memory-side snoop responder.
package snoop_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 3;
    localparam int NBLOCKS  = 1 << ADDR_W;
    localparam int WORD_W   = DATA_W + 4 + ADDR_W;

    localparam int ADDR_LO  = 0;
    localparam int ADDR_HI  = ADDR_W - 1;
    localparam int OP_LO    = ADDR_W;
    localparam int OP_HI    = ADDR_W + 1;
    localparam int RPLY_BIT = ADDR_W + 2;
    localparam int WB_BIT   = ADDR_W + 3;
    localparam int DATA_LO  = ADDR_W + 4;
    localparam int DATA_HI  = WORD_W - 1;

    typedef enum logic [1:0] {
        OP_NONE   = 2'b00,
        OP_RDMISS = 2'b01,
        OP_WRMISS = 2'b10,
        OP_INV    = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_REPLY = 2'b10
    } state_t;

    function automatic logic [WORD_W-1:0] makeReply(input logic [DATA_W-1:0] data,
                                                    input op_t op,
                                                    input logic [ADDR_W-1:0] addr);
        return {data, 1'b0, 1'b1, op, addr};
    endfunction

endpackage

// File: rtl/snoop_memory_responder_if.sv
// Bus-side signals of the memory responder: snooped bus word in, arbiter request and busy out.
interface snoop_memory_responder_if;
    import snoop_pkg::*;

    logic [WORD_W-1:0] BusWire;
    logic [WORD_W-1:0] BarramentoMemoria;
    logic              busy;

    modport slave  (input BusWire, output BarramentoMemoria, output busy);
    modport master (output BusWire, input BarramentoMemoria, input busy);

endinterface

// File: rtl/snoop_mem_array.sv
// Block store: one synchronous write port, one asynchronous read port, resets to index values.
module snoop_mem_array
    import snoop_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [NBLOCKS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NBLOCKS; i++) begin
                r_mem[i] <= DATA_W'(i);
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/snoop_memory_responder.sv
// Memory endpoint of the snooping bus: absorbs write-backs, answers misses after LATENCY edges.
module snoop_memory_responder
    import snoop_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    snoop_memory_responder_if.slave bus
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t            r_state,  w_stateNx;
    logic [CNT_W-1:0]  r_cnt,    w_cntNx;
    logic [ADDR_W-1:0] r_addr,   w_addrNx;
    op_t               r_op,     w_opNx;
    logic [WORD_W-1:0] r_out,    w_outNx;
    logic              r_busy,   w_busyNx;

    logic [DATA_W-1:0] w_data;
    logic              w_wb;
    logic              w_rply;
    op_t               w_op;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_cancel;

    assign w_data = bus.BusWire[DATA_HI:DATA_LO];
    assign w_wb   = bus.BusWire[WB_BIT];
    assign w_rply = bus.BusWire[RPLY_BIT];
    assign w_op   = op_t'(bus.BusWire[OP_HI:OP_LO]);
    assign w_addr = bus.BusWire[ADDR_HI:ADDR_LO];

    // An owning cache writing back the pending block supplies it directly, so memory backs off.
    assign w_cancel = w_wb && (w_addr == r_addr);

    snoop_mem_array u_mem (
        .clock   (clock),
        .reset_n (reset_n),
        .i_we    (w_wb),
        .i_waddr (w_addr),
        .i_wdata (w_data),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_op    <= OP_NONE;
            r_out   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_stateNx;
            r_cnt   <= w_cntNx;
            r_addr  <= w_addrNx;
            r_op    <= w_opNx;
            r_out   <= w_outNx;
            r_busy  <= w_busyNx;
        end
    end

    always_comb begin
        w_stateNx = r_state;
        w_cntNx   = r_cnt;
        w_addrNx  = r_addr;
        w_opNx    = r_op;
        w_outNx   = r_out;
        w_busyNx  = r_busy;
        case (r_state)
            S_IDLE: begin
                if (!w_wb && !w_rply && (w_op == OP_RDMISS || w_op == OP_WRMISS)) begin
                    w_stateNx = S_WAIT;
                    w_addrNx  = w_addr;
                    w_opNx    = w_op;
                    w_busyNx  = 1'b1;
                    w_cntNx   = CNT_W'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (w_cancel) begin
                    w_stateNx = S_IDLE;
                    w_outNx   = '0;
                    w_busyNx  = 1'b0;
                end else if (r_cnt == '0) begin
                    w_stateNx = S_REPLY;
                    w_outNx   = makeReply(w_rdata, r_op, r_addr);
                end else begin
                    w_cntNx = r_cnt - CNT_W'(1);
                end
            end
            S_REPLY: begin
                if (w_cancel || (bus.BusWire == r_out)) begin
                    w_stateNx = S_IDLE;
                    w_outNx   = '0;
                    w_busyNx  = 1'b0;
                end
            end
            default: begin
                w_stateNx = S_IDLE;
                w_outNx   = '0;
                w_busyNx  = 1'b0;
            end
        endcase
    end

    assign bus.BarramentoMemoria = r_out;
    assign bus.busy              = r_busy;

endmodule
